// File: rtl/ad_capture.sv
// ad_capture: dual ADC frame controller, 4-channel deserializer and block averager.
module ad_capture #(
  parameter int SAMPLE_PERIOD = 24,
  parameter int AVG_LOG = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  output logic        ad_cs,
  input  logic [1:0]  ad_sdata_a,
  input  logic [1:0]  ad_sdata_b,
  output logic [11:0] ci_sample,
  output logic [11:0] cv_sample,
  output logic [11:0] li_sample,
  output logic [11:0] lv_sample,
  output logic        sample_valid,
  output logic [11:0] ci_avg,
  output logic [11:0] cv_avg,
  output logic [11:0] li_avg,
  output logic [11:0] lv_avg,
  output logic        avg_valid
);
  localparam int PER = SAMPLE_PERIOD < 18 ? 18 : SAMPLE_PERIOD;
  localparam int QW = $clog2(PER);
  localparam logic [QW-1:0] K16 = QW'(16);
  localparam logic [QW-1:0] QEND = QW'(PER - 16);
  localparam logic [4:0] FLAST = 5'((1 << AVG_LOG) - 1);
  typedef enum logic [1:0] {IDLE, CONV, QUIET} state_t;
  state_t state, state_nx;
  logic [QW-1:0] cnt, cnt_nx;
  logic [3:0] din;
  logic [11:0] sh [4];
  logic [11:0] smp [4];
  logic [11:0] avg [4];
  logic [15:0] acc [4];
  logic [15:0] sum [4];
  logic [4:0] fcnt;
  logic shift_en, deliver, last;
  // cnt holds the frame edge index k that the next clock edge represents
  always_comb begin
    state_nx = state;
    cnt_nx = cnt + 1'b1;
    unique case (state)
      IDLE: begin
        state_nx = run ? CONV : IDLE;
        cnt_nx = QW'(1);
      end
      CONV: if (cnt == K16) begin
        state_nx = QUIET;
        cnt_nx = QW'(1);
      end
      QUIET: if (cnt == QEND) begin
        state_nx = run ? CONV : IDLE;
        cnt_nx = QW'(1);
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      ad_cs <= 1'b1;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      ad_cs <= state_nx != CONV;
    end
  end
  assign shift_en = state == CONV && cnt >= QW'(4) && cnt <= QW'(15);
  assign deliver = state == CONV && cnt == K16;
  assign last = fcnt == FLAST;
  always_comb begin
    for (int i = 0; i < 4; i++) sum[i] = acc[i] + {4'b0, sh[i]};
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      din <= '0;
      fcnt <= '0;
      sample_valid <= 1'b0;
      avg_valid <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        sh[i] <= '0;
        smp[i] <= '0;
        avg[i] <= '0;
        acc[i] <= '0;
      end
    end else begin
      din <= {ad_sdata_b[1], ad_sdata_a[1], ad_sdata_b[0], ad_sdata_a[0]};
      sample_valid <= deliver;
      avg_valid <= deliver && last;
      if (deliver) fcnt <= last ? '0 : fcnt + 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (shift_en) sh[i] <= {sh[i][10:0], din[i]};
        if (deliver) begin
          smp[i] <= sh[i];
          acc[i] <= last ? '0 : sum[i];
          if (last) avg[i] <= 12'(sum[i] >> AVG_LOG);
        end
      end
    end
  end
  assign ci_sample = smp[0];
  assign cv_sample = smp[1];
  assign li_sample = smp[2];
  assign lv_sample = smp[3];
  assign ci_avg = avg[0];
  assign cv_avg = avg[1];
  assign li_avg = avg[2];
  assign lv_avg = avg[3];
endmodule

// File: tb/tb_ad_capture.sv
// tb_ad_capture: ADC pad model, frame-timeline reference model and directed/random stimulus.
module tb_ad_capture;
  localparam int P = 24;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n = 1'b0, run = 1'b0;
  logic [1:0] sa = 2'b11, sb = 2'b11;
  logic ad_cs, sample_valid, avg_valid;
  logic [11:0] ci_sample, cv_sample, li_sample, lv_sample, ci_avg, cv_avg, li_avg, lv_avg;
  logic run2 = 1'b1;
  logic [1:0] sa2 = '0, sb2 = '0;
  logic cs2, sv2, av2;
  logic [11:0] ci2, cv2, li2, lv2, cia2, cva2, lia2, lva2;

  ad_capture #(.SAMPLE_PERIOD(P), .AVG_LOG(3)) u_dut (
    .clk(clk), .reset_n(reset_n), .run(run), .ad_cs(ad_cs),
    .ad_sdata_a(sa), .ad_sdata_b(sb),
    .ci_sample(ci_sample), .cv_sample(cv_sample), .li_sample(li_sample), .lv_sample(lv_sample),
    .sample_valid(sample_valid),
    .ci_avg(ci_avg), .cv_avg(cv_avg), .li_avg(li_avg), .lv_avg(lv_avg),
    .avg_valid(avg_valid));

  ad_capture #(.SAMPLE_PERIOD(10), .AVG_LOG(0)) u_clamp (
    .clk(clk), .reset_n(reset_n), .run(run2), .ad_cs(cs2),
    .ad_sdata_a(sa2), .ad_sdata_b(sb2),
    .ci_sample(ci2), .cv_sample(cv2), .li_sample(li2), .lv_sample(lv2),
    .sample_valid(sv2),
    .ci_avg(cia2), .cv_avg(cva2), .li_avg(lia2), .lv_avg(lva2),
    .avg_valid(av2));

  int checks = 0, failures = 0;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ADC model: word chosen at frame start, 2 leading 1s, 12 data bits MSB first, trailing 1s
  logic [11:0] nxt [4];
  bit inc = 0, rnd = 0;
  int base_fc = 0, fc = 0, kk = 0;
  logic [11:0] cur [4];
  logic [47:0] wq[$];
  function automatic logic padbit(input logic [11:0] w, input int k);
    logic [11:0] s;
    s = w >> (14 - k);
    return (k >= 3 && k <= 14) ? s[0] : 1'b1;
  endfunction
  always @(posedge clk) begin
    #1;
    kk = ad_cs ? 0 : kk + 1;
    if (kk == 1) begin
      for (int i = 0; i < 4; i++)
        cur[i] = rnd ? 12'($urandom) : nxt[i] + (inc ? 12'(fc - base_fc) : 12'd0);
      fc++;
      wq.push_back({cur[3], cur[2], cur[1], cur[0]});
    end
    sa = {padbit(cur[2], kk), padbit(cur[0], kk)};
    sb = {padbit(cur[3], kk), padbit(cur[1], kk)};
    sa2 = 2'($urandom);
    sb2 = 2'($urandom);
  end

  // Reference model: timeline of edges p since the frame's ad_cs fall
  bit busy = 0, started = 0, m_sv = 0, m_av = 0, m_cs = 1;
  int p = 0, m_n = 0;
  int m_smp [4] = '{0, 0, 0, 0};
  int m_avg [4] = '{0, 0, 0, 0};
  int m_acc [4] = '{0, 0, 0, 0};
  logic [47:0] w;
  always @(posedge clk) begin
    started = 1;
    m_sv = 0;
    m_av = 0;
    if (!reset_n) begin
      busy = 0;
      p = 0;
      m_n = 0;
      wq.delete();
      for (int i = 0; i < 4; i++) begin m_smp[i] = 0; m_avg[i] = 0; m_acc[i] = 0; end
    end else if (!busy) begin
      if (run) begin busy = 1; p = 0; end
    end else begin
      p++;
      if (p == 16) begin
        w = wq.size() > 0 ? wq.pop_front() : '0;
        m_sv = 1;
        m_n++;
        for (int i = 0; i < 4; i++) begin
          m_smp[i] = int'(w[12*i +: 12]);
          m_acc[i] += m_smp[i];
        end
        if (m_n == 8) begin
          m_av = 1;
          m_n = 0;
          for (int i = 0; i < 4; i++) begin m_avg[i] = m_acc[i] / 8; m_acc[i] = 0; end
        end
      end
      if (p == P) begin
        if (run) p = 0;
        else busy = 0;
      end
    end
    m_cs = !(busy && p < 16);
  end

  int tot_low = 0, tot_sv = 0, t = 0, hi = 0, last_fall = 0, nfalls = 0;
  bit seen = 0, prev2 = 1;
  always @(negedge clk) begin
    t++;
    if (started) begin
      chk("ad_cs", ad_cs, m_cs);
      chk("sample_valid", sample_valid, m_sv);
      chk("avg_valid", avg_valid, m_av);
      chk("ci_sample", ci_sample, m_smp[0]);
      chk("cv_sample", cv_sample, m_smp[1]);
      chk("li_sample", li_sample, m_smp[2]);
      chk("lv_sample", lv_sample, m_smp[3]);
      chk("ci_avg", ci_avg, m_avg[0]);
      chk("cv_avg", cv_avg, m_avg[1]);
      chk("li_avg", li_avg, m_avg[2]);
      chk("lv_avg", lv_avg, m_avg[3]);
      tot_low += int'(!ad_cs);
      tot_sv += int'(sample_valid);
      if (!reset_n) begin
        seen = 0;
        hi = 0;
        prev2 = 1;
      end else begin
        if (cs2) hi++;
        else if (prev2) begin
          if (seen) begin
            chk("clamp_gap", hi, 2);
            chk("clamp_period", t - last_fall, 18);
            nfalls++;
          end
          seen = 1;
          last_fall = t;
          hi = 0;
        end
        prev2 = cs2;
        chk("clamp_avg_valid", av2, sv2);
        chk("clamp_avg", {cia2, cva2, lia2, lva2} == {ci2, cv2, li2, lv2}, 1);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic setw(input int a, input int b, input int c, input int d, input bit i, input bit r);
    nxt[0] = 12'(a); nxt[1] = 12'(b); nxt[2] = 12'(c); nxt[3] = 12'(d);
    inc = i;
    rnd = r;
    base_fc = fc;
  endtask
  task automatic do_reset();
    reset_n = 0;
    cyc(2);
    reset_n = 1;
    cyc(2);
  endtask
  task automatic frames(input int n, output int np, output int avp);
    int lastj;
    np = 0;
    avp = 0;
    lastj = 0;
    run = 1;
    for (int j = 0; j < 60 * n && np < n; j++) begin
      @(posedge clk); #1;
      if (sample_valid) begin
        np++;
        if (np > 1) chk("pulse_period", j - lastj, P);
        lastj = j;
        if (avg_valid) avp = np;
      end
    end
    run = 0;
  endtask

  int lat, l0, s0, np, avp;
  initial begin
    setw(0, 0, 0, 0, 0, 0);
    do_reset();
    chk("rst_cs", ad_cs, 1);
    chk("rst_sv", sample_valid, 0);
    chk("rst_ci", ci_sample, 0);
    chk("rst_avg", lv_avg, 0);
    // single frame with leading/trailing bits forced high
    setw('hA5C, 'h001, 'hFFF, 'h800, 0, 0);
    l0 = tot_low; s0 = tot_sv; lat = 0;
    run = 1;
    for (int j = 1; j <= 40; j++) begin
      @(posedge clk); #1;
      if (j == 1) run = 0;
      if (sample_valid && lat == 0) lat = j;
    end
    chk("single_latency", lat, 17);
    chk("single_low_cycles", tot_low - l0, 16);
    chk("single_pulses", tot_sv - s0, 1);
    chk("single_ci", ci_sample, 'hA5C);
    chk("single_cv", cv_sample, 'h001);
    chk("single_li", li_sample, 'hFFF);
    chk("single_lv", lv_sample, 'h800);
    // continuous run, incrementing words 1..10
    do_reset();
    setw(1, 1, 1, 1, 1, 0);
    s0 = tot_sv;
    frames(10, np, avp);
    chk("cont_value", ci_sample, 10);
    cyc(60);
    chk("cont_pulses", tot_sv - s0, 10);
    // averaging 100..107, then full scale
    do_reset();
    setw(100, 100, 100, 100, 1, 0);
    frames(8, np, avp);
    chk("avg_at_frame", avp, 8);
    chk("avg_cv", cv_avg, 103);
    chk("avg_ci", ci_avg, 103);
    cyc(30);
    setw('hFFF, 'hFFF, 'hFFF, 'hFFF, 0, 0);
    frames(8, np, avp);
    chk("fullscale_at_frame", avp, 8);
    chk("fullscale_ci", ci_avg, 'hFFF);
    chk("fullscale_lv", lv_avg, 'hFFF);
    cyc(30);
    // stop mid-frame: run low sampled at k=5
    setw('h123, 'h234, 'h345, 'h456, 0, 0);
    l0 = tot_low; s0 = tot_sv;
    run = 1;
    cyc(5);
    run = 0;
    cyc(80);
    chk("stop_low_cycles", tot_low - l0, 16);
    chk("stop_pulses", tot_sv - s0, 1);
    chk("stop_ci", ci_sample, 'h123);
    chk("stop_lv", lv_sample, 'h456);
    // reset at k=8
    setw('h3C3, 'h3C3, 'h3C3, 'h3C3, 0, 0);
    run = 1;
    cyc(8);
    reset_n = 0;
    run = 0;
    cyc(1);
    reset_n = 1;
    chk("midrst_cs", ad_cs, 1);
    chk("midrst_ci", ci_sample, 0);
    chk("midrst_avg", cv_avg, 0);
    s0 = tot_sv;
    cyc(30);
    chk("midrst_pulses", tot_sv - s0, 0);
    setw('h456, 'h567, 'h678, 'h789, 0, 0);
    run = 1;
    cyc(1);
    run = 0;
    cyc(30);
    chk("clean_pulses", tot_sv - s0, 1);
    chk("clean_ci", ci_sample, 'h456);
    chk("clean_lv", lv_sample, 'h789);
    // randomized words and run toggling against the model
    setw(0, 0, 0, 0, 0, 1);
    for (int j = 0; j < 4000; j++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 29) == 0) run = ~run;
    end
    run = 0;
    cyc(40);
    chk("clamp_frames_seen", int'(nfalls > 10), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
